// File: rtl/inner_fn_issuer.sv
// inner_fn_issuer: streams cmd_count source words through the pipelined
// inner-function unit and writes the in-order results to a destination memory.
//
// state | meaning
// IDLE  | waiting for an accepted cmd_start
// ISSUE | one source read per enabled cycle; operands follow into the unit
// DRAIN | all reads issued, collecting the remaining results
// DONE  | one-cycle cmd_done pulse, then back to IDLE
// ERROR | no result within TIMEOUT cycles; error set, back to IDLE
module inner_fn_issuer #(
   parameter int ADDR_W     = 10,
   parameter int CNT_W      = 10,
   parameter int FN_LATENCY = 13,
   parameter int TIMEOUT    = 64
) (
   input  logic              clock,
   input  logic              aclr_n,
   input  logic              clk_en,
   input  logic              cmd_start,
   input  logic [ADDR_W-1:0] cmd_src_base,
   input  logic [ADDR_W-1:0] cmd_dst_base,
   input  logic [CNT_W-1:0]  cmd_count,
   output logic              busy,
   output logic              cmd_done,
   output logic              error,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [31:0]       rd_data,
   output logic              fn_start,
   output logic [31:0]       fn_dataa,
   input  logic [31:0]       fn_result,
   input  logic              fn_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   // A nominal unit must be able to return its first result before the timer fires.
   if (TIMEOUT <= FN_LATENCY) begin : g_bad_timeout
      $error("inner_fn_issuer: TIMEOUT must exceed FN_LATENCY");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_DRAIN = 3'd2,
      S_DONE  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [ADDR_W-1:0] src_base;
   logic [ADDR_W-1:0] dst_base;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  issued;
   logic [CNT_W-1:0]  fn_issued;
   logic [CNT_W-1:0]  returned;
   logic              rd_valid_q;
   logic              error_q;
   logic [TMO_W-1:0]  tmo_left;

   logic              in_busy;
   logic              accept;
   logic              rd_fire;
   logic              fn_fire;
   logic              wr_fire;
   logic              stall;
   logic              tmo_expire;

   // Strobe qualification, timeout detection and next-state selection.
   always_comb begin
      state_nxt  = state;
      in_busy    = (state == S_ISSUE) || (state == S_DRAIN);
      accept     = clk_en && cmd_start && (state == S_IDLE);
      rd_fire    = clk_en && (state == S_ISSUE);
      // An operand already read when the block errors out is not sent on.
      fn_fire    = clk_en && rd_valid_q && in_busy;
      wr_fire    = clk_en && fn_done && in_busy;
      stall      = clk_en && in_busy && !fn_done && (fn_issued > returned);
      tmo_expire = stall && (tmo_left <= TMO_W'(1));

      if (clk_en) begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state_nxt = (cmd_count == '0) ? S_DONE : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (tmo_expire) begin
                  state_nxt = S_ERROR;
               end else if (issued == count_q - CNT_W'(1)) begin
                  state_nxt = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (tmo_expire) begin
                  state_nxt = S_ERROR;
               end else if (wr_fire && (returned == count_q - CNT_W'(1))) begin
                  state_nxt = S_DONE;
               end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERROR: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Output decode; all strobes derive from the async-reset state so reset kills them at once.
   always_comb begin
      busy     = in_busy;
      cmd_done = clk_en && (state == S_DONE);
      error    = error_q;
      rd_en    = rd_fire;
      rd_addr  = src_base + ADDR_W'(issued);
      fn_start = fn_fire;
      fn_dataa = rd_data;
      wr_en    = wr_fire;
      wr_addr  = dst_base + ADDR_W'(returned);
      wr_data  = fn_result;
   end

   // State register.
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         state <= S_IDLE;
      end else if (clk_en) begin
         state <= state_nxt;
      end
   end

   // Read-valid pipeline stage: rd_data lands one cycle after rd_en.
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         rd_valid_q <= 1'b0;
      end else if (clk_en) begin
         rd_valid_q <= rd_fire;
      end
   end

   // Command latch, issue/return counters, timeout down-counter and sticky error.
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         src_base  <= '0;
         dst_base  <= '0;
         count_q   <= '0;
         issued    <= '0;
         fn_issued <= '0;
         returned  <= '0;
         tmo_left  <= '0;
         error_q   <= 1'b0;
      end else if (accept) begin
         src_base  <= cmd_src_base;
         dst_base  <= cmd_dst_base;
         count_q   <= cmd_count;
         issued    <= '0;
         fn_issued <= '0;
         returned  <= '0;
         tmo_left  <= TMO_W'(TIMEOUT);
         error_q   <= 1'b0;
      end else if (clk_en) begin
         if (rd_fire) begin
            issued <= issued + CNT_W'(1);
         end
         if (fn_fire) begin
            fn_issued <= fn_issued + CNT_W'(1);
         end
         if (wr_fire) begin
            returned <= returned + CNT_W'(1);
         end
         if (fn_done) begin
            tmo_left <= TMO_W'(TIMEOUT);
         end else if (stall) begin
            tmo_left <= tmo_left - TMO_W'(1);
         end
         if (tmo_expire) begin
            error_q <= 1'b1;
         end
      end
   end

endmodule
